// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-and-add multiplier that drives a shared Hack-style ALU.
// Optional sticky overflow flag when MUL_OVF_EN is defined; otherwise ovf is tied low.
//
// state | meaning
// IDLE  | ALU parked on constant zero, waiting for start
// DBL   | acc <- acc + acc via ALU, test multiplier bit idx
// ADD   | acc <- acc + a_q via ALU, step to next bit
// DONE  | one-cycle done pulse, result already registered
module alu_mul_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic         alu_zx,
  output logic         alu_nx,
  output logic         alu_zy,
  output logic         alu_ny,
  output logic         alu_f,
  output logic         alu_no,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zr,
  input  logic         alu_ng
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DBL,
    S_ADD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q, acc_q, result_q;
  logic [IW-1:0] idx_q;
  logic          last_bit;

  // Flags are available from the ALU but the sequence never needs them.
  logic unused_flags;
  assign unused_flags = &{1'b0, alu_zr, alu_ng};

  assign last_bit = (idx_q == '0);
  assign busy     = (state_q == S_DBL) || (state_q == S_ADD);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    alu_x   = '0;
    alu_y   = '0;
    alu_zx  = 1'b1;
    alu_nx  = 1'b0;
    alu_zy  = 1'b1;
    alu_ny  = 1'b0;
    alu_f   = 1'b1;
    alu_no  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_DBL;
      end
      S_DBL: begin
        alu_x  = acc_q;
        alu_y  = acc_q;
        alu_zx = 1'b0;
        alu_zy = 1'b0;
        if (b_q[idx_q])    state_d = S_ADD;
        else if (last_bit) state_d = S_DONE;
        else               state_d = S_DBL;
      end
      S_ADD: begin
        alu_x  = acc_q;
        alu_y  = a_q;
        alu_zx = 1'b0;
        alu_zy = 1'b0;
        state_d = last_bit ? S_DONE : S_DBL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= IW'(W - 1);
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            idx_q <= IW'(W - 1);
          end
        end
        S_DBL: begin
          acc_q <= alu_out;
          // idx holds when branching to ADD; ADD performs the step instead.
          if (!b_q[idx_q] && !last_bit) idx_q <= idx_q - 1'b1;
          if (state_d == S_DONE) result_q <= alu_out;
        end
        S_ADD: begin
          acc_q <= alu_out;
          if (!last_bit) idx_q <= idx_q - 1'b1;
          if (state_d == S_DONE) result_q <= alu_out;
        end
        default: ;
      endcase
    end
  end

`ifdef MUL_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) ovf_q <= 1'b0;
        S_DBL:  if (acc_q[W-1]) ovf_q <= 1'b1;
        S_ADD:  if (alu_out < acc_q) ovf_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
